// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared clock constants, tick FSM states and rate-to-increment helper
package clock_pkg;

  localparam int unsigned PLL_CLK_HZ = 24_000_000;
  localparam int unsigned CRYSTAL_HZ = 12_000_000;

  typedef enum logic {
    SETTLE = 1'b0,
    RUN    = 1'b1
  } tick_state_t;

  // Rounded phase increment giving rate_hz ticks from PLL_CLK_HZ with an acc_width-bit accumulator.
  function automatic longint unsigned rate_to_inc(input longint unsigned rate_hz,
                                                  input int unsigned acc_width);
    return ((rate_hz << acc_width) + 64'(PLL_CLK_HZ / 2)) / 64'(PLL_CLK_HZ);
  endfunction

endpackage

// File: rtl/pll_tick_gen_phase_accumulator.sv
// rtl/pll_tick_gen_phase_accumulator.sv - registered phase accumulator with loadable increment and carry out
module phase_accumulator #(
  parameter int unsigned       WIDTH     = 24,
  parameter logic [WIDTH-1:0]  RESET_INC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             carry
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] inc;
  logic [WIDTH:0]   sum;

  assign sum   = {1'b0, acc} + {1'b0, inc};
  assign carry = enable & sum[WIDTH];

  // A load on an add edge takes effect next edge; acc is never cleared so phase stays continuous.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      inc <= RESET_INC;
    end else begin
      if (enable) acc <= sum[WIDTH-1:0];
      if (load)   inc <= load_data;
    end
  end

endmodule

// File: rtl/pll_tick_gen.sv
// rtl/pll_tick_gen.sv - PLL settle window, ready flag and phase-accumulator rate ticks
module pll_tick_gen
  import clock_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4096,
  parameter int unsigned ACC_WIDTH     = 24,
  parameter int unsigned DEFAULT_INC   = 32'(rate_to_inc(64'd1_843_200, 24)),
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                 pll_clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 inc_load,
  input  logic [ACC_WIDTH-1:0] inc_data,
  output logic                 ready,
  output logic                 tick,
  output logic [CNT_WIDTH-1:0] tick_count
);

  localparam int unsigned     SW          = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  tick_state_t   state;
  tick_state_t   next_state;
  logic [SW-1:0] settle_cnt;
  logic          run_enable;
  logic          carry;

  always_ff @(posedge pll_clock) begin
    if (reset) state <= SETTLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (state == SETTLE && settle_cnt == SETTLE_LAST) next_state = RUN;
  end

  // ready is a pure decode of the registered state, so it is glitch-free.
  always_comb begin
    ready      = 1'b0;
    run_enable = 1'b0;
    case (state)
      RUN: begin
        ready      = 1'b1;
        run_enable = enable;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pll_clock) begin
    if (reset)                 settle_cnt <= '0;
    else if (state == SETTLE)  settle_cnt <= settle_cnt + 1'b1;
  end

  phase_accumulator #(
    .WIDTH     (ACC_WIDTH),
    .RESET_INC (ACC_WIDTH'(DEFAULT_INC))
  ) u_acc (
    .clk       (pll_clock),
    .reset     (reset),
    .enable    (run_enable),
    .load      (inc_load),
    .load_data (inc_data),
    .carry     (carry)
  );

  always_ff @(posedge pll_clock) begin
    if (reset) begin
      tick       <= 1'b0;
      tick_count <= '0;
    end else begin
      tick <= carry;
      if (carry) tick_count <= tick_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pll_tick_gen.sv
// tb/tb_pll_tick_gen.sv - scoreboard bench for pll_tick_gen with small settle and accumulator widths
module tb_pll_tick_gen;

  logic       pll_clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       inc_load;
  logic [7:0] inc_data;
  logic       ready;
  logic       tick;
  logic [3:0] tick_count;

  always #5 pll_clock = ~pll_clock;

  pll_tick_gen #(
    .SETTLE_CYCLES (8),
    .ACC_WIDTH     (8),
    .DEFAULT_INC   (128),
    .CNT_WIDTH     (4)
  ) dut (
    .pll_clock  (pll_clock),
    .reset      (reset),
    .enable     (enable),
    .inc_load   (inc_load),
    .inc_data   (inc_data),
    .ready      (ready),
    .tick       (tick),
    .tick_count (tick_count)
  );

  typedef struct packed {
    logic       ready;
    logic       tick;
    logic [3:0] tc;
    logic [7:0] acc;
    logic [7:0] inc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic       m_run;
  int         m_cnt;
  logic [7:0] m_acc;
  logic [7:0] m_inc;
  logic       m_tick;
  logic [3:0] m_tc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the reference one edge from the current inputs, clock the DUT, then compare.
  task automatic step();
    logic [8:0] sum;
    exp_t       e;
    if (reset) begin
      m_run = 1'b0; m_cnt = 0; m_acc = 8'd0; m_inc = 8'd128; m_tick = 1'b0; m_tc = 4'd0;
    end else begin
      if (!m_run) begin
        if (m_cnt == 7) m_run = 1'b1;
        m_cnt++;
        m_tick = 1'b0;
      end else if (enable) begin
        sum    = {1'b0, m_acc} + {1'b0, m_inc};
        m_acc  = sum[7:0];
        m_tick = sum[8];
        if (m_tick) m_tc = m_tc + 4'd1;
      end else begin
        m_tick = 1'b0;
      end
      if (inc_load) m_inc = inc_data;
    end
    sb.push_back('{m_run, m_tick, m_tc, m_acc, m_inc});
    @(posedge pll_clock);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("cyc_ready", ready, e.ready);
      check("cyc_tick", tick, e.tick);
      check("cyc_count", tick_count, e.tc);
      check("cyc_acc", dut.u_acc.acc, e.acc);
      check("cyc_inc", dut.u_acc.inc, e.inc);
    end
  endtask

  initial begin
    int         ticks;
    int         last;
    int         n;
    logic [7:0] t2_acc [4];
    t2_acc = '{8'd85, 8'd170, 8'd255, 8'd84};

    // 1: reset, settle window, first ticks at INC=128
    reset = 1'b1; enable = 1'b0; inc_load = 1'b0; inc_data = 8'd0;
    repeat (3) step();
    check("rst_ready", ready, 0);
    check("rst_tick", tick, 0);
    check("rst_count", tick_count, 0);
    check("rst_acc", dut.u_acc.acc, 0);
    check("rst_inc", dut.u_acc.inc, 128);
    reset = 1'b0; enable = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("t1_settle_ready", ready, 32'(k == 8));
      check("t1_settle_tick", tick, 0);
    end
    step();
    check("t1_run1_tick", tick, 0);
    check("t1_run1_acc", dut.u_acc.acc, 128);
    for (int k = 0; k < 4; k++) begin
      step();
      check("t1_tick_alt", tick, 32'(k % 2 == 0));
    end

    // 2: load 85 during settle, 85 ticks in 256 RUN edges with gaps of 3 or 4
    reset = 1'b1; step();
    reset = 1'b0; inc_load = 1'b1; inc_data = 8'd85; step();
    inc_load = 1'b0;
    repeat (7) step();
    check("t2_ready", ready, 1);
    check("t2_inc", dut.u_acc.inc, 85);
    ticks = 0; last = -1;
    for (int e = 1; e <= 256; e++) begin
      step();
      if (e <= 4) check("t2_acc_seq", dut.u_acc.acc, t2_acc[e-1]);
      if (e == 4) check("t2_first_tick", tick, 1);
      if (tick) begin
        ticks++;
        if (last >= 0) check("t2_gap", 32'((e - last == 3) || (e - last == 4)), 1);
        last = e;
      end
    end
    check("t2_ticks", ticks, 85);

    // 3: enable dropped for 5 cycles holds acc and suppresses ticks
    reset = 1'b1; step();
    reset = 1'b0;
    repeat (8) step();
    step();
    step();
    check("t3_tick", tick, 1);
    check("t3_acc0", dut.u_acc.acc, 0);
    step();
    check("t3_acc128", dut.u_acc.acc, 128);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t3_hold_tick", tick, 0);
      check("t3_hold_acc", dut.u_acc.acc, 128);
    end
    enable = 1'b1;
    step();
    check("t3_resume", tick, 1);

    // 4: load 64 on an add edge; that edge still adds 128
    step();
    check("t4_acc128", dut.u_acc.acc, 128);
    inc_load = 1'b1; inc_data = 8'd64; step();
    inc_load = 1'b0;
    check("t4_tick", tick, 1);
    check("t4_acc0", dut.u_acc.acc, 0);
    check("t4_inc", dut.u_acc.inc, 64);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("t4_every4", tick, 32'(k % 4 == 0));
    end

    // 5: tick_count runs through a full 4-bit wrap
    reset = 1'b1; step();
    reset = 1'b0;
    repeat (8) step();
    n = 0;
    for (int k = 0; k < 32; k++) begin
      step();
      if (tick) begin
        n++;
        check("t5_count", tick_count, 32'(n % 16));
        check("t5_ready", ready, 1);
      end
    end
    check("t5_ticks", n, 16);

    // 6: reset mid-RUN ignores a simultaneous inc_load, then settle repeats
    reset = 1'b1; inc_load = 1'b1; inc_data = 8'd7; step();
    reset = 1'b0; inc_load = 1'b0;
    check("t6_ready", ready, 0);
    check("t6_tick", tick, 0);
    check("t6_count", tick_count, 0);
    check("t6_inc", dut.u_acc.inc, 128);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("t6_settle_ready", ready, 32'(k == 8));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_tick_gen.md
Name: pll_tick_gen

Overview:
- Consumes the 24 MHz `pll_clock` produced by the iCE40 PLL stage (12 MHz crystal, DIVF=63, DIVQ=5).
- Holds downstream logic idle for a fixed settle window while the PLL output stabilises, then asserts `ready`.
- After `ready`, generates single-cycle clock-enable ticks at a programmable rate using a phase accumulator. Default rate is a 16x UART baud enable.
- Sits between the PLL wrapper and every fabric block that needs `ready` or a rate enable.

Parameters:
- SETTLE_CYCLES, 4096: `pll_clock` cycles from reset release to `ready`. Must be ≥1.
- ACC_WIDTH, 24: phase accumulator width in bits.
- DEFAULT_INC, 1288490: increment loaded at reset. 1843200 Hz × 2^24 / 24 MHz, rounded.
- CNT_WIDTH, 16: width of `tick_count`.

Ports:
- pll_clock  in  1  sole clock, from PLL PLLOUTCORE.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = accumulator advances in RUN.
- inc_load  in  1  1 = capture `inc_data` this edge.
- inc_data  in  ACC_WIDTH  new phase increment.
- ready  out  1  high once the settle window has elapsed.
- tick  out  1  single-cycle rate enable, registered.
- tick_count  out  CNT_WIDTH  number of ticks issued, wraps.

Behaviour:
- One clock domain, `pll_clock`. Reset is synchronous and active-high; all state is updated only on rising edges.
- Reset values:
  - state = SETTLE, settle_cnt = 0, acc = 0, inc_reg = DEFAULT_INC
  - ready = 0, tick = 0, tick_count = 0
- Reset asserted at any time, including mid-RUN, restores all reset values on that edge. Any `inc_load` on the same edge is ignored.
- SETTLE state:
  - settle_cnt (width $clog2(SETTLE_CYCLES+1)) increments every edge.
  - On the edge where settle_cnt == SETTLE_CYCLES-1: state → RUN and ready ← 1.
  - `ready` is therefore first high after exactly SETTLE_CYCLES edges with reset low.
  - acc is held and tick = 0; `enable` is ignored.
- RUN state: terminal until reset; `ready` stays 1.
  - enable = 1: {carry, acc} ← acc + inc_reg, a (ACC_WIDTH+1)-bit sum; tick ← carry.
  - enable = 0: acc held, tick ← 0.
  - Tick rate is inc_reg / 2^ACC_WIDTH × f(pll_clock). Ticks are never back-to-back unless inc_reg ≥ 2^(ACC_WIDTH-1).
- tick_count:
  - Increments on every edge where tick is being set to 1.
  - It therefore equals the number of tick pulses including the one currently presented.
  - Wraps modulo 2^CNT_WIDTH without a flag.
- inc_load:
  - Accepted in any state (not during reset): inc_reg ← inc_data.
  - An add on the same edge uses the old inc_reg. The new value applies from the next edge.
  - acc is not cleared, so there is no phase discontinuity.
- inc_data = 0: acc frozen, no ticks. This is a legal stop mechanism.
- Latency: tick is registered. The carry out of the add on edge N is visible as tick=1 during the cycle after edge N.

Decomposition:
- Shared package `clock_pkg`:
  - PLL_CLK_HZ = 24_000_000 and CRYSTAL_HZ = 12_000_000.
  - State enum typedef `tick_state_t` {SETTLE, RUN}.
  - Helper function computing an increment from a target rate.
- One natural sub-module, `phase_accumulator`:
  - Width-parameterised registered add with carry.
  - Enable, increment register and load port.
  - Reusable for NCO work.
- `pll_tick_gen` owns the settle FSM, `ready` and `tick_count`.

Test Plan (bench parameters: SETTLE_CYCLES=8, ACC_WIDTH=8, CNT_WIDTH=4, DEFAULT_INC=128):
1. Reset 3 cycles, release, enable=1 -> ready=0 and tick=0 for 8 edges. ready=1 after the 8th edge. First tick=1 in the cycle after the 2nd RUN edge, then every 2nd cycle.
2. inc_load with inc_data=85 during SETTLE, enable=1 -> over the first 256 RUN edges exactly 85 ticks. Gaps between ticks are 3 or 4 cycles only; acc sequence 85, 170, 255, 84 (tick).
3. RUN with INC=128, enable dropped for 5 cycles between ticks -> tick=0 for those 5 cycles, acc value unchanged. Tick resumes 1 or 2 edges after enable returns, according to the held acc.
4. INC=128, acc=128, then inc_load with inc_data=64 on an add edge -> that edge adds 128 (tick=1 next cycle, acc=0). Subsequent ticks every 4 cycles.
5. 16 ticks at INC=128 -> tick_count runs 1..15 then 0 on the 16th tick. No other output is disturbed.
6. Reset asserted mid-RUN with inc_load=1, inc_data=7 on the same edge -> next cycle: ready=0, tick=0, tick_count=0, inc_reg=128. After release, the 8-cycle settle window repeats.
